// File: rtl/cache_line_burst_engine.sv
`timescale 1ns/1ps
// cache_line_burst_engine: moves one cache line between the cache and
// word-wide main memory, as a read burst (fill) or a write burst (writeback).
// Optional feature: define CRITICAL_WORD_FIRST_EN to start every burst at the
// requested word and present the first filled word on crit_valid/crit_word.
module cache_line_burst_engine #(
  parameter  int WORD_SIZE      = 32,
  parameter  int WORDS_PER_LINE = 8,
  localparam int LINE_BITS      = $clog2(WORDS_PER_LINE)
) (
  input  logic                                clk,
  input  logic                                clr_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [WORD_SIZE-1:0]                req_addr,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_wdata,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_rdata,
  output logic                                done,
  output logic                                crit_valid,
  output logic [WORD_SIZE-1:0]                crit_word,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [WORD_SIZE-1:0]                mem_addr,
  output logic [WORD_SIZE-1:0]                mem_wdata,
  input  logic                                mem_ack,
  input  logic [WORD_SIZE-1:0]                mem_rdata
);

  localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'(WORDS_PER_LINE * 4 - 1);

  typedef enum logic [1:0] {IDLE, FILL, WB, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LINE_BITS-1:0] cnt;
  logic [LINE_BITS-1:0] beats;
  logic [LINE_BITS-1:0] start_cnt;
  logic [WORD_SIZE-1:0] base;
  logic [WORD_SIZE-1:0] beat_off;
  logic [WORD_SIZE-1:0] wr_words [WORDS_PER_LINE];
  logic [WORD_SIZE-1:0] line_buf [WORDS_PER_LINE];
  logic                 accept;
  logic                 beat_ack;
  logic                 last_beat;

  assign accept    = (state == IDLE) && req_valid;
  assign beat_ack  = ((state == FILL) || (state == WB)) && mem_ack;
  assign last_beat = (beats == LINE_BITS'(WORDS_PER_LINE - 1));
  assign beat_off  = WORD_SIZE'({cnt, 2'b00});

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_cnt = req_addr[LINE_BITS+1:2];
`else
  assign start_cnt = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/memory-side outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_write ? WB : FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = base + beat_off;
        if (mem_ack && last_beat) begin
          state_nxt = DONE;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base + beat_off;
        mem_wdata = wr_words[cnt];
        if (mem_ack && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counters and line base address
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt   <= '0;
      beats <= '0;
      base  <= '0;
    end else if (accept) begin
      cnt   <= start_cnt;
      beats <= '0;
      base  <= req_addr & ~OFF_MASK;
    end else if (beat_ack) begin
      cnt   <= cnt + LINE_BITS'(1);
      beats <= beats + LINE_BITS'(1);
    end
  end

  // Line storage: writeback copy latched at accept, fill buffer written per beat
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
        wr_words[i] <= line_wdata[i*WORD_SIZE +: WORD_SIZE];
      end
    end
    if (clr_n && (state == FILL) && mem_ack) begin
      line_buf[cnt] <= mem_rdata;
    end
  end

  // Pack the fill buffer onto the line output
  always_comb begin
    line_rdata = '0;
    for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
      line_rdata[i*WORD_SIZE +: WORD_SIZE] = line_buf[i];
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic                 crit_valid_q;
  logic [WORD_SIZE-1:0] crit_word_q;

  // First fill beat is the requested word; flag it for one cycle
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      crit_valid_q <= (state == FILL) && mem_ack && (beats == '0);
      if ((state == FILL) && mem_ack && (beats == '0)) begin
        crit_word_q <= mem_rdata;
      end
    end
  end

  assign crit_valid = crit_valid_q;
  assign crit_word  = crit_word_q;
`else
  assign crit_valid = 1'b0;
  assign crit_word  = '0;
`endif

endmodule

// File: tb/tb_cache_line_burst_engine.sv
`timescale 1ns/1ps
// Self-checking bench for cache_line_burst_engine: a transaction-level model
// predicts every output each cycle; directed tests pin the model with literals.
module tb_cache_line_burst_engine;

  localparam int WS = 32;
  localparam int N  = 8;
  localparam int LW = WS * N;
  localparam logic [WS-1:0] LMASK = WS'(N * 4 - 1);

  logic          clk = 1'b0;
  logic          clr_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [WS-1:0] req_addr;
  logic [LW-1:0] line_wdata;
  logic [LW-1:0] line_rdata;
  logic          done;
  logic          crit_valid;
  logic [WS-1:0] crit_word;
  logic          mem_req;
  logic          mem_we;
  logic [WS-1:0] mem_addr;
  logic [WS-1:0] mem_wdata;
  logic          mem_ack;
  logic [WS-1:0] mem_rdata;

  always #5 clk = ~clk;

  cache_line_burst_engine #(.WORD_SIZE(WS), .WORDS_PER_LINE(N)) dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .done(done), .crit_valid(crit_valid),
    .crit_word(crit_word), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkl(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: 0 = ack always high, 1 = ack every third cycle, else no ack
  int ack_mode = 2;
  int div      = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rdata = mem_addr ^ 32'hA5A5_0000;
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: begin
          mem_ack = (div == 2);
          div     = (div + 1) % 3;
        end
        default: mem_ack = 1'b0;
      endcase
    end
  end

  // Transaction model: a line transfer is N acked beats over word indices
  // (start + k) mod N, followed by one done cycle.
  logic          m_ok     = 1'b0;
  logic          m_active = 1'b0;
  logic          m_write  = 1'b0;
  logic          m_done   = 1'b0;
  logic          m_crit   = 1'b0;
  logic          m_known  = 1'b0;
  int unsigned   m_k      = 0;
  int unsigned   m_start  = 0;
  logic [WS-1:0] m_base   = '0;
  logic [WS-1:0] m_critw  = '0;
  logic [LW-1:0] m_wline  = '0;
  logic [WS-1:0] m_line [N];

  always @(posedge clk) begin
    m_done <= 1'b0;
    m_crit <= 1'b0;
    if (!clr_n) begin
      m_ok     <= 1'b1;
      m_active <= 1'b0;
    end else if (!m_active && !m_done) begin
      if (req_valid) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_write  <= req_write;
        m_base   <= req_addr & ~LMASK;
        m_wline  <= line_wdata;
`ifdef CRITICAL_WORD_FIRST_EN
        m_start  <= (req_addr >> 2) % N;
`else
        m_start  <= 0;
`endif
        if (!req_write) m_known <= 1'b0;
      end
    end else if (m_active && mem_ack) begin
      if (!m_write) begin
        m_line[(m_start + m_k) % N] <= mem_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
        if (m_k == 0) begin
          m_crit  <= 1'b1;
          m_critw <= mem_rdata;
        end
`endif
      end
      if (m_k == N - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        if (!m_write) m_known <= 1'b1;
      end
      m_k <= m_k + 1;
    end
  end

  // Event log for the directed tests
  int            acc_cyc = 0, acc_count = 0;
  int            done_cyc = 0, done_count = 0;
  int            last_ack_cyc = 0;
  int            crit_count = 0;
  logic [WS-1:0] crit_seen = '0;
  logic [WS-1:0] beat_addr [$];
  logic [WS-1:0] beat_data [$];
  logic          beat_we [$];

  // Compare DUT against the model every cycle, mid-period
  always @(negedge clk) begin : cmp
    int unsigned   idx;
    logic [LW-1:0] exp_line;
    if (m_ok) begin
      chk1("req_ready", req_ready, !m_active && !m_done);
      chk1("done", done, m_done);
      chk1("mem_req", mem_req, m_active);
      chk1("mem_we", mem_we, m_active && m_write);
      if (m_active) begin
        idx = (m_start + m_k) % N;
        chkw("mem_addr", mem_addr, m_base + idx * 4);
        if (m_write) chkw("mem_wdata", mem_wdata, m_wline[idx*WS +: WS]);
      end else if (!m_done) begin
        chkw("idle_mem_addr", mem_addr, '0);
        chkw("idle_mem_wdata", mem_wdata, '0);
      end
      chk1("crit_valid", crit_valid, m_crit);
`ifdef CRITICAL_WORD_FIRST_EN
      if (m_crit) chkw("crit_word", crit_word, m_critw);
`else
      chkw("crit_word", crit_word, '0);
`endif
      if (m_known) begin
        exp_line = '0;
        for (int i = 0; i < N; i++) exp_line[i*WS +: WS] = m_line[i];
        chkl("line_rdata", line_rdata, exp_line);
      end
    end
    if (req_valid && req_ready) begin
      acc_cyc = cyc;
      acc_count++;
    end
    if (done) begin
      done_cyc = cyc;
      done_count++;
    end
    if (mem_req && mem_ack) begin
      beat_addr.push_back(mem_addr);
      beat_data.push_back(mem_wdata);
      beat_we.push_back(mem_we);
      last_ack_cyc = cyc;
    end
    if (crit_valid) begin
      crit_count++;
      crit_seen = crit_word;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    beat_addr.delete();
    beat_data.delete();
    beat_we.delete();
  endtask

  task automatic wait_done(input string name, input int max);
    int start;
    bit seen;
    start = done_count;
    seen  = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (done_count != start) seen = 1'b1;
    end
    chk1(name, seen, 1'b1);
  endtask

  task automatic issue(input logic wr, input logic [WS-1:0] addr);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int            s, c0, d0, a0, nwe;
    logic [WS-1:0] found;
    logic [WS-1:0] e0, e1;
    int            ecrit;
`ifdef CRITICAL_WORD_FIRST_EN
    s = 5;
`else
    s = 0;
`endif
    clr_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    line_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_crit_valid", crit_valid, 1'b0);
    chkw("rst_crit_word", crit_word, 32'h0);
    chkw("rst_mem_addr", mem_addr, 32'h0);
    chkw("rst_mem_wdata", mem_wdata, 32'h0);
    step();
    clr_n    = 1'b1;
    ack_mode = 0;
    step();
    step();

    // Fill, zero-wait memory
    clear_log();
    c0 = crit_count;
    issue(1'b0, 32'h0000_1234);
    wait_done("t1_done_seen", 40);
    chkw("t1_latency", done_cyc - acc_cyc, 9);
    chkw("t1_beats", beat_addr.size(), 8);
    for (int k = 0; k < 8; k++) chkw("t1_addr_seq", beat_addr[k], 32'h1220 + ((s + k) % 8) * 4);
    chkw("t1_word2", line_rdata[2*WS +: WS], 32'hA5A5_1228);
`ifdef CRITICAL_WORD_FIRST_EN
    chkw("t1_crit_count", crit_count - c0, 1);
    chkw("t1_crit_word", crit_seen, 32'hA5A5_1234);
`else
    chkw("t1_crit_count", crit_count - c0, 0);
`endif

    // Acks while idle must be ignored
    d0 = done_count;
    repeat (4) step();
    chk1("spur_ready", req_ready, 1'b1);
    chkw("spur_done_count", done_count - d0, 0);
    chkw("spur_word2", line_rdata[2*WS +: WS], 32'hA5A5_1228);
    chkw("spur_word7", line_rdata[7*WS +: WS], 32'hA5A5_123C);

    // Writeback, ack every third cycle
    ack_mode = 1;
    for (int i = 0; i < N; i++) line_wdata[i*WS +: WS] = 32'h1000_0000 + i;
    clear_log();
    issue(1'b1, 32'h8000_0000);
    wait_done("t2_done_seen", 100);
    chkw("t2_beats", beat_addr.size(), 8);
    nwe = 0;
    for (int k = 0; k < beat_we.size(); k++) if (beat_we[k]) nwe++;
    chkw("t2_we_count", nwe, 8);
    chkw("t2_first_addr", beat_addr[0], 32'h8000_0000);
    found = '0;
    for (int k = 0; k < beat_addr.size(); k++) if (beat_addr[k] == 32'h8000_001C) found = beat_data[k];
    chkw("t2_word7_data", found, 32'h1000_0007);
    chkw("t2_done_after_ack", done_cyc - last_ack_cyc, 1);
    chkw("t2_fill_line_kept", line_rdata[0 +: WS], 32'hA5A5_1220);

    // req_valid held high across a whole fill
    ack_mode = 0;
    a0 = acc_count;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_2008;
    for (int i = 0; i < 40 && (acc_count - a0) < 2; i++) step();
    req_valid = 1'b0;
    chkw("t3_accepts", acc_count - a0, 2);
    chkw("t3_second_accept_gap", acc_cyc - done_cyc, 1);
    wait_done("t3_second_done", 40);
    chkw("t3_word1", line_rdata[1*WS +: WS], 32'hA5A5_2004);

    // Reset after three fill acks
    clear_log();
    d0 = done_count;
    issue(1'b0, 32'h0000_3000);
    for (int i = 0; i < 20 && beat_addr.size() < 3; i++) step();
    chkw("t4_acks_before_reset", beat_addr.size(), 3);
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    @(negedge clk);
    chk1("t4_mem_req", mem_req, 1'b0);
    chk1("t4_req_ready", req_ready, 1'b1);
    chk1("t4_done", done, 1'b0);
    repeat (12) step();
    chkw("t4_no_done", done_count - d0, 0);

    // Normal fill after the aborted one
    clear_log();
    issue(1'b0, 32'h0000_4010);
    wait_done("t5_done_seen", 40);
    chkw("t5_latency", done_cyc - acc_cyc, 9);
    chkw("t5_word0", line_rdata[0 +: WS], 32'hA5A5_4000);
    chkw("t5_word4", line_rdata[4*WS +: WS], 32'hA5A5_4010);

    // Request at the last word of a line
`ifdef CRITICAL_WORD_FIRST_EN
    e0 = 32'h0000_001C;
    e1 = 32'h0000_0000;
    ecrit = 1;
`else
    e0 = 32'h0000_0000;
    e1 = 32'h0000_0004;
    ecrit = 0;
`endif
    clear_log();
    c0 = crit_count;
    issue(1'b0, 32'h0000_001C);
    wait_done("t6_done_seen", 40);
    chkw("t6_first_addr", beat_addr[0], e0);
    chkw("t6_second_addr", beat_addr[1], e1);
    chkw("t6_crit_count", crit_count - c0, ecrit);
`ifdef CRITICAL_WORD_FIRST_EN
    chkw("t6_crit_word", crit_seen, 32'hA5A5_001C);
`endif
    chkw("t6_word7", line_rdata[7*WS +: WS], 32'hA5A5_001C);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_burst_engine.md
Name: cache_line_burst_engine

Overview:
- Parametrised successor to the line adapter.
- Moves one whole cache line between the cache and word-wide main memory, in either direction:
  - Fill: a memory read burst into a line buffer.
  - Writeback: a memory write burst out of a latched line.
- Request side uses a valid/ready handshake; memory side uses a per-beat req/ack handshake.
- Sits between the L1 cache controllers and the memory arbiter.

Parameters:
- WORD_SIZE, 32, bits per word and per address.
- WORDS_PER_LINE, 8, words per line; power of two, at least 2.
- LINE_BITS, $clog2(WORDS_PER_LINE), derived; not overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- clr_n  in  1  synchronous active-low reset.
- req_valid  in  1  cache requests a line transfer.
- req_ready  out  1  engine idle; a request is accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = writeback, 0 = fill; sampled at accept.
- req_addr  in  WORD_SIZE  any byte address inside the target line.
- line_wdata  in  WORD_SIZE*WORDS_PER_LINE  writeback line; word i is bits [i*WORD_SIZE +: WORD_SIZE]; sampled at accept.
- line_rdata  out  WORD_SIZE*WORDS_PER_LINE  filled line, same packing.
- done  out  1  one-cycle pulse when the transfer completes.
- crit_valid  out  1  critical word available (see Optional Feature).
- crit_word  out  WORD_SIZE  critical word data.
- mem_req  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  WORD_SIZE  beat byte address.
- mem_wdata  out  WORD_SIZE  beat write data.
- mem_ack  in  1  memory completes the current beat.
- mem_rdata  in  WORD_SIZE  read data; valid when mem_ack is high.

Behaviour:
- Reset (clr_n low at an edge):
  - State goes to IDLE; beat counter and beats-done counter clear to 0.
  - req_ready=1; done=0; mem_req=0; mem_we=0; crit_valid=0; crit_word=0.
  - mem_addr and mem_wdata are 0 in IDLE.
  - The line buffer is not cleared; line_rdata is don't-care after reset.
- States: IDLE, FILL, WB, DONE.
- IDLE:
  - req_ready=1.
  - On accept, latch:
    - base = req_addr with its low LINE_BITS+2 bits zeroed;
    - word offset = req_addr[LINE_BITS+1:2];
    - req_write;
    - line_wdata.
  - Load counters, then go to FILL or WB on the next edge.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = base + (cnt << 2).
  - On mem_ack: buffer[cnt] <= mem_rdata; cnt increments modulo WORDS_PER_LINE; beats-done increments.
  - After the ack with beats-done == WORDS_PER_LINE-1, go to DONE.
  - mem_req stays high across consecutive beats; back-to-back acks on consecutive cycles are legal.
- WB:
  - mem_req=1, mem_we=1, mem_addr as in FILL, mem_wdata = latched word[cnt].
  - Advances on mem_ack exactly as FILL does; mem_rdata is ignored.
- DONE:
  - done=1 for exactly one cycle; req_ready=0.
  - Go to IDLE.
  - line_rdata holds the filled line until the next fill writes the buffer.
- Latency with zero-wait memory (mem_ack tied high): accept edge, then WORDS_PER_LINE beat cycles, then 1 DONE cycle, so done is high WORDS_PER_LINE+1 cycles after accept.
- req_ready=0 in FILL, WB and DONE; req_valid is ignored there.
- mem_ack outside FILL/WB is ignored.
- mem_addr arithmetic is modulo 2^WORD_SIZE; a line never crosses its aligned boundary.
- Reset mid-burst: mem_req drops in the cycle after the reset edge; the partial line is discarded; no done pulse.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - cnt starts at the word offset and wraps modulo WORDS_PER_LINE, so beats cover all words exactly once.
  - In FILL, on the first ack, the next cycle has crit_valid=1 for one cycle with crit_word = that beat's data.
  - WB also starts at the word offset; crit_valid stays 0 in WB.
- Undefined:
  - cnt starts at 0.
  - crit_valid and crit_word are tied to 0.

Test Plan:
- Fill, zero-wait, req_addr=0x0000_1234, memory returns addr^0xA5A5_0000:
  - mem_addr sequence 0x1220 through 0x123C in steps of 4 (start 0x1234 with the macro defined, wrapping to 0x1220);
  - done 9 cycles after accept;
  - line_rdata word 2 = 0xA5A5_1228.
- Writeback, line_wdata word i = 0x1000_0000+i, req_addr=0x8000_0000, acks every 3rd cycle:
  - 8 writes with mem_we=1;
  - word 7 written to 0x8000_001C;
  - done follows the last ack by 1 cycle.
- req_valid held high during a fill:
  - req_ready=0 throughout;
  - the second request is accepted only in the cycle after done.
- clr_n low for 1 cycle after 3 fill acks:
  - mem_req=0 next cycle, IDLE, req_ready=1, no done;
  - a following fill completes normally.
- Spurious mem_ack in IDLE:
  - no state change, buffer unchanged.
- With CRITICAL_WORD_FIRST_EN, req_addr=0x1C:
  - first mem_addr=0x1C, second 0x00;
  - crit_valid pulses once with word 7 data.
